// File: rtl/snake_pkg.sv
// Shared constants and encodings for the snake game: VGA 640x480@60 timing,
// movement directions, game states and the snake colour.
package snake_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4
   } direction_e;

   typedef enum logic {
      PLAY      = 1'b0,
      GAME_OVER = 1'b1
   } game_state_e;

   localparam logic [11:0] SNAKE_RGB = 12'h0F0;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate / sync / game-strobe bundle from the timing generator
// (master) to the draw blocks (slave).
interface vga_timing_gen_if #(
   parameter int BIT = 10
);
   logic [BIT-1:0] x_pos;
   logic [BIT-1:0] y_pos;
   logic           hsync;
   logic           vsync;
   logic           video_active;
   logic           frame_tick;
   logic           update;

   modport master (
      output x_pos, y_pos, hsync, vsync, video_active, frame_tick, update
   );

   modport slave (
      input  x_pos, y_pos, hsync, vsync, video_active, frame_tick, update
   );
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Enable-gated modulo-N counter; wrap flags the enabled last-value edge so
// counters can be chained.
module mod_counter #(
   parameter int WIDTH  = 10,
   parameter int MODULO = 800
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

   if (MODULO < 1 || (MODULO - 1) >= (1 << WIDTH)) begin : g_bad_modulo
      $error("mod_counter: MODULO does not fit in WIDTH bits");
   end

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      wrap    = en && (count_q == LAST);
      count_d = count_q;
      if (wrap) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y pixel counters, sync/active decodes, and the
// vblank-aligned frame_tick and game-rate update strobes.
module vga_timing_gen #(
   parameter int BIT               = 10,
   parameter int H_ACTIVE          = snake_pkg::H_ACTIVE,
   parameter int H_FP              = snake_pkg::H_FP,
   parameter int H_SYNC            = snake_pkg::H_SYNC,
   parameter int H_BP              = snake_pkg::H_BP,
   parameter int V_ACTIVE          = snake_pkg::V_ACTIVE,
   parameter int V_FP              = snake_pkg::V_FP,
   parameter int V_SYNC            = snake_pkg::V_SYNC,
   parameter int V_BP              = snake_pkg::V_BP,
   parameter int FRAMES_PER_UPDATE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_en,
   input  logic              update_en,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FW      = int'(snake_pkg::cnt_width(FRAMES_PER_UPDATE));

   localparam logic [BIT-1:0] HS_START = BIT'(H_ACTIVE + H_FP);
   localparam logic [BIT-1:0] HS_END   = BIT'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [BIT-1:0] VS_START = BIT'(V_ACTIVE + V_FP);
   localparam logic [BIT-1:0] VS_END   = BIT'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BIT-1:0] X_VIS    = BIT'(H_ACTIVE);
   localparam logic [BIT-1:0] Y_VIS    = BIT'(V_ACTIVE);
   localparam logic [BIT-1:0] Y_PRE_VB = BIT'(V_ACTIVE - 1);
   localparam logic [FW-1:0]  F_LAST   = FW'(FRAMES_PER_UPDATE - 1);

   if ((H_TOTAL - 1) >= (1 << BIT) || (V_TOTAL - 1) >= (1 << BIT)
       || FRAMES_PER_UPDATE < 1) begin : g_bad_params
      $error("vga_timing_gen: totals exceed BIT bits or FRAMES_PER_UPDATE < 1");
   end

   logic [BIT-1:0] x_cnt;
   logic [BIT-1:0] y_cnt;
   logic [FW-1:0]  frame_cnt;
   logic           h_wrap;
   logic           v_wrap;
   logic           frame_wrap;

   mod_counter #(.WIDTH(BIT), .MODULO(H_TOTAL)) u_h_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en),
      .count (x_cnt),
      .wrap  (h_wrap)
   );

   mod_counter #(.WIDTH(BIT), .MODULO(V_TOTAL)) u_v_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (h_wrap),
      .count (y_cnt),
      .wrap  (v_wrap)
   );

   mod_counter #(.WIDTH(FW), .MODULO(FRAMES_PER_UPDATE)) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (v_wrap),
      .count (frame_cnt),
      .wrap  (frame_wrap)
   );

   always_comb assert (!frame_wrap || v_wrap);

   logic tick_d, tick_q;
   logic update_d, update_q;

   // The only edge that loads (0, V_ACTIVE) is a line wrap out of the last
   // visible row; h_wrap already implies pix_en, so pulses self-clear.
   always_comb begin
      tick_d   = h_wrap && (y_cnt == Y_PRE_VB);
      update_d = tick_d && update_en && (frame_cnt == F_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q   <= 1'b0;
         update_q <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         update_q <= update_d;
      end
   end

   assign vga.x_pos        = x_cnt;
   assign vga.y_pos        = y_cnt;
   assign vga.hsync        = !((x_cnt >= HS_START) && (x_cnt < HS_END));
   assign vga.vsync        = !((y_cnt >= VS_START) && (y_cnt < VS_END));
   assign vga.video_active = (x_cnt < X_VIS) && (y_cnt < Y_VIS);
   assign vga.frame_tick   = tick_q;
   assign vga.update       = update_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a scaled-down raster (15x10)
// with a reference model feeding a per-cycle scoreboard.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
   localparam int FPU    = 8;
   localparam int HT     = HA + HFP + HS + HBP;
   localparam int VT     = VA + VFP + VS + VBP;
   localparam int FRAME  = HT * VT;
   localparam int TICK_P = VA * HT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;
   logic update_en = 1'b0;

   vga_timing_gen_if #(.BIT(10)) vif ();
   vga_timing_gen_if #(.BIT(10)) vif1 ();

   vga_timing_gen #(
      .BIT(10), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FRAMES_PER_UPDATE(FPU)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .update_en(update_en), .vga(vif)
   );

   vga_timing_gen #(
      .BIT(10), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FRAMES_PER_UPDATE(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .update_en(update_en), .vga(vif1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   x;
      int   y;
      logic hs, vs, act, tick, upd, upd1;
   } exp_t;

   typedef struct {
      int   n;
      int   x;
      int   y;
      logic hs, vs, act;
   } vec_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc, dut_ticks, hs_low, vs_low, act_cnt;
   int   m_p, m_ticks;
   logic m_tick, m_upd, m_upd1;
   int   tick_cycles[$];
   int   upd_frames[$];
   vec_t vecs[14];

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step();
      exp_t e;
      if (pix_en) begin
         m_p    = (m_p + 1) % FRAME;
         m_tick = (m_p == TICK_P);
         if (m_tick) m_ticks++;
         m_upd  = m_tick && update_en && (m_ticks % FPU == 0);
         m_upd1 = m_tick && update_en;
      end else begin
         m_tick = 1'b0;
         m_upd  = 1'b0;
         m_upd1 = 1'b0;
      end
      e.x    = m_p % HT;
      e.y    = m_p / HT;
      e.hs   = !(e.x >= HA + HFP && e.x < HA + HFP + HS);
      e.vs   = !(e.y >= VA + VFP && e.y < VA + VFP + VS);
      e.act  = (e.x < HA) && (e.y < VA);
      e.tick = m_tick;
      e.upd  = m_upd;
      e.upd1 = m_upd1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = sbq.pop_front();
      chk("x_pos", int'(vif.x_pos), e.x);
      chk("y_pos", int'(vif.y_pos), e.y);
      chk("hsync", int'(vif.hsync), int'(e.hs));
      chk("vsync", int'(vif.vsync), int'(e.vs));
      chk("video_active", int'(vif.video_active), int'(e.act));
      chk("frame_tick", int'(vif.frame_tick), int'(e.tick));
      chk("update", int'(vif.update), int'(e.upd));
      chk("update_fpu1", int'(vif1.update), int'(e.upd1));
      chk("frame_tick_fpu1", int'(vif1.frame_tick), int'(e.tick));
      if (!vif.hsync) hs_low++;
      if (!vif.vsync) vs_low++;
      if (vif.video_active) act_cnt++;
      if (vif.frame_tick) begin
         dut_ticks++;
         tick_cycles.push_back(cyc);
      end
      if (vif.update) upd_frames.push_back(dut_ticks);
   endtask

   // Asserts reset between clock edges and checks the outputs before any edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_x_pos", int'(vif.x_pos), 0);
      chk("rst_y_pos", int'(vif.y_pos), 0);
      chk("rst_hsync", int'(vif.hsync), 1);
      chk("rst_vsync", int'(vif.vsync), 1);
      chk("rst_video_active", int'(vif.video_active), 1);
      chk("rst_frame_tick", int'(vif.frame_tick), 0);
      chk("rst_update", int'(vif.update), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_p = 0; m_ticks = 0;
      m_tick = 1'b0; m_upd = 1'b0; m_upd1 = 1'b0;
      cyc = 0; dut_ticks = 0; hs_low = 0; vs_low = 0; act_cnt = 0;
      tick_cycles.delete();
      upd_frames.delete();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      vecs[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{7,   7,  0, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{8,   8,  0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{10,  10, 0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{12,  12, 0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{13,  13, 0, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{14,  14, 0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{15,  0,  1, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{89,  14, 5, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{90,  0,  6, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{105, 0,  7, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{134, 14, 8, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{135, 0,  9, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{150, 0,  0, 1'b1, 1'b1, 1'b1};

      // Continuous pixel enable: raster table, one-frame statistics, 17 frames.
      do_reset();
      pix_en = 1'b1;
      update_en = 1'b1;
      for (int i = 0; i < 14; i++) begin
         run_to(vecs[i].n);
         chk("tbl_x_pos", int'(vif.x_pos), vecs[i].x);
         chk("tbl_y_pos", int'(vif.y_pos), vecs[i].y);
         chk("tbl_hsync", int'(vif.hsync), int'(vecs[i].hs));
         chk("tbl_vsync", int'(vif.vsync), int'(vecs[i].vs));
         chk("tbl_video_active", int'(vif.video_active), int'(vecs[i].act));
      end
      chk("hsync_low_per_frame", hs_low, HS * VT);
      chk("vsync_low_per_frame", vs_low, VS * HT);
      chk("active_per_frame", act_cnt, HA * VA);
      run_to(17 * FRAME);
      chk("tick_count_17", dut_ticks, 17);
      if (tick_cycles.size() > 0) chk("first_tick_cycle", tick_cycles[0], TICK_P);
      for (int i = 1; i < tick_cycles.size(); i++)
         chk("tick_period", tick_cycles[i] - tick_cycles[i-1], FRAME);
      chk("update_count_17", upd_frames.size(), 2);
      if (upd_frames.size() == 2) begin
         chk("update_frame_a", upd_frames[0], 8);
         chk("update_frame_b", upd_frames[1], 16);
      end

      // Pixel enable at half rate: every period doubles, pulses stay 1 clk.
      do_reset();
      update_en = 1'b1;
      for (int i = 0; i < 4 * FRAME; i++) begin
         pix_en = (i % 2 == 0);
         step();
         if (i == 2 * HT - 1) chk("half_rate_line_y", int'(vif.y_pos), 1);
      end
      chk("half_rate_tick_count", dut_ticks, 2);
      if (tick_cycles.size() == 2)
         chk("half_rate_tick_period", tick_cycles[1] - tick_cycles[0], 2 * FRAME);

      // update_en low across the 8th vblank: the divider keeps counting.
      do_reset();
      pix_en = 1'b1;
      update_en = 1'b1;
      run_to(7 * FRAME);
      update_en = 1'b0;
      run_to(8 * FRAME);
      update_en = 1'b1;
      run_to(17 * FRAME);
      chk("gated_update_count", upd_frames.size(), 1);
      if (upd_frames.size() == 1) chk("gated_update_frame", upd_frames[0], 16);

      // Mid-frame asynchronous reset, then restart from zero.
      do_reset();
      pix_en = 1'b1;
      update_en = 1'b1;
      run_to(3 * HT + 5);
      chk("pre_reset_x", int'(vif.x_pos), 5);
      chk("pre_reset_y", int'(vif.y_pos), 3);
      do_reset();
      run_to(9 * FRAME);
      chk("post_reset_update_count", upd_frames.size(), 1);
      if (upd_frames.size() == 1) chk("post_reset_update_frame", upd_frames[0], 8);
      if (tick_cycles.size() > 7) chk("post_reset_update_cycle", tick_cycles[7], 7 * FRAME + TICK_P);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA timing and the pixel coordinates consumed by the snake, food and score draw blocks. It drives x_pos/y_pos, hsync/vsync and video_active. It also produces the game-rate `update` strobe that advances the snake by one cell every FRAMES_PER_UPDATE frames. It sits between the pixel-clock enable and all draw_* blocks. It is the producer side of the x_pos/y_pos/update interface.

Parameters:
BIT, 10, width of x_pos/y_pos
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
FRAMES_PER_UPDATE, 8, frames per update strobe (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset: asynchronous, active-low
pix_en  in  1  pixel clock enable; counters advance only when high
update_en  in  1  gates `update`; frame divider keeps running regardless
x_pos  out  BIT  horizontal count 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800)
y_pos  out  BIT  vertical count 0..V_TOTAL-1 (V_TOTAL = sum of V_*, 525)
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
video_active  out  1  high when x_pos<H_ACTIVE and y_pos<V_ACTIVE
frame_tick  out  1  one-clk pulse at the start of every vertical blank
update  out  1  one-clk pulse at the start of vertical blank, every FRAMES_PER_UPDATE frames

Behaviour:
- Reset: asynchronous, active-low. Values while rst_n=0: x_pos=0, y_pos=0, frame_cnt=0, frame_tick=0, update=0. Combinational decodes give hsync=1, vsync=1, video_active=1.
- Asserting rst_n=0 mid-frame returns all state to the reset values immediately, independent of clk.
- Horizontal counter, on a clk edge with pix_en=1:
  - x_pos=H_TOTAL-1 wraps to 0; otherwise x_pos increments by 1.
- Vertical counter, on the same edge:
  - Increments only when x wraps.
  - y_pos=V_TOTAL-1 wraps to 0 when x wraps.
- pix_en=0: every register holds its value, except that any pulse output currently high returns to 0.
- Sync and active decodes: combinational from the registered counters, so zero latency relative to x_pos/y_pos.
  - hsync=0 iff H_ACTIVE+H_FP <= x_pos < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync=0 iff V_ACTIVE+V_FP <= y_pos < V_ACTIVE+V_FP+V_SYNC (490..491).
- Frame divider (frame_cnt, 0..FRAMES_PER_UPDATE-1):
  - Increments when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Wraps to 0 after FRAMES_PER_UPDATE-1.
- frame_tick: registered. It is 1 for exactly the first clk cycle in which (x_pos,y_pos)=(0,V_ACTIVE); it is set on the edge that loads those counter values.
- update: same timing as frame_tick, additionally qualified by frame_cnt==FRAMES_PER_UPDATE-1 and update_en=1 at that edge.
- Pulse width is exactly one clk, even if pix_en is high for many cycles.
- Placing update in vblank guarantees that snake/food state never changes during visible pixels.
- FRAMES_PER_UPDATE=1: update coincides with every frame_tick.
- Arithmetic: counters are unsigned BIT bits. H_TOTAL-1 and V_TOTAL-1 must fit in BIT bits; this is a static assertion in simulation.

Decomposition:
- Package snake_pkg holds:
  - VGA timing constants: H_* and V_* values, plus H_TOTAL and V_TOTAL.
  - direction encodings: IDLE/UP/DOWN/LEFT/RIGHT.
  - game_state encodings: PLAY/GAME_OVER.
  - SNAKE_RGB.
- One sub-module, mod_counter (parameters WIDTH, MODULO; ports clk, rst_n, en, count, wrap):
  - wrap is combinational: en && count==MODULO-1.
  - Instantiated for horizontal, vertical and frame counters, chained through wrap.

Test Plan:
- Reset, then pix_en=1 constantly → x_pos reaches 799 and returns to 0 after 800 clks; y_pos=1 at clk 800; hsync low exactly for x=656..751 (96 clks).
- Run one full frame → frame period 420000 clks; vsync low for y=490..491 (1600 clks); video_active high 307200 clks per frame.
- Run 17 frames with update_en=1 → frame_tick every 420000 clks, each 1 clk wide at (0,480); update on frames 8 and 16 only.
- pix_en toggling 1/0 → all periods double (line = 1600 clks); frame_tick and update remain exactly 1 clk wide.
- update_en=0 across frame 8, then 1 → no update on frame 8; next update on frame 16 (divider not reset).
- Drop rst_n at x=300, y=200, asynchronously between clk edges → outputs immediately x=0, y=0, hsync=1, vsync=1; counting resumes from 0 after release; first update after 8 frames.
